alu_cmd_seq: RTL and testbench

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_core.sv | 35 +++
 rtl/alu_cmd_seq.sv | 107 ++++++++++
 tb/tb_alu_cmd_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the accumulator command sequencer.
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADD1 = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: f = op(a, b), cout = carry of the (WIDTH+1)-bit sum for add ops.
// Latency: 0 cycles.
// Backpressure: none, pure datapath.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] f,
    output logic             cout
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADD1)};
        f    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        case (op)
            OP_AND: begin
                f    = a & b;
                cout = 1'b0;
            end
            OP_XOR: begin
                f    = a ^ b;
                cout = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Accepts a command, applies it to the accumulator rep+1 times (load: once), presents the result.
// Latency: handshake at edge T, iterations at T+1..T+rep+1, res_valid the cycle after.
// Backpressure: result held until res_ready; no new command accepted until then.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [REP_W-1:0] cmd_rep,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_acc,
    output logic             res_carry,
    output logic             busy
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [REP_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [WIDTH-1:0] alu_f;
    logic             alu_cout;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .a    (acc_q),
        .b    (b_q),
        .op   (op_q),
        .f    (alu_f),
        .cout (alu_cout)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_acc   = acc_q;
    assign res_carry = carry_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        load_d  = load_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    load_d  = cmd_load;
                    b_d     = cmd_b;
                    // A load is a single iteration whatever rep says.
                    cnt_d   = cmd_load ? '0 : cmd_rep;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d   = load_q ? b_q : alu_f;
                carry_d = load_q ? 1'b0 : alu_cout;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            load_q  <= 1'b0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            load_q  <= load_d;
            b_q     <= b_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench: chained command table with scoreboard, plus a mid-EXEC reset sequence.
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_load;
    logic [3:0] cmd_b;
    logic [2:0] cmd_rep;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_acc;
    logic       res_carry;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       load;
        logic [1:0] op;
        logic [3:0] b;
        logic [2:0] rep;
        int         hold;
        logic [3:0] acc;
        logic       carry;
    } vec_t;

    typedef struct {
        logic [3:0] acc;
        logic       carry;
        int         lat;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_cmd_seq #(.WIDTH(4), .REP_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_load  (cmd_load),
        .cmd_b     (cmd_b),
        .cmd_rep   (cmd_rep),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_acc   (res_acc),
        .res_carry (res_carry),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        int   n;
        logic [3:0] held_acc;
        @(negedge clk);
        chk($sformatf("v%0d cmd_ready idle", idx), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_load  = v.load;
        cmd_op    = v.op;
        cmd_b     = v.b;
        cmd_rep   = v.rep;
        @(posedge clk);
        e.acc   = v.acc;
        e.carry = v.carry;
        e.lat   = (v.load ? 1 : int'(v.rep) + 1) + 1;
        sb.push_back(e);
        @(negedge clk);
        n = 1;
        // Scramble the command inputs: the latched copy must be unaffected.
        cmd_valid = 1'b0;
        cmd_load  = ~v.load;
        cmd_op    = ~v.op;
        cmd_b     = ~v.b;
        cmd_rep   = ~v.rep;
        chk($sformatf("v%0d busy in exec", idx), {busy, cmd_ready}, 2'b10);
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        got = sb.pop_front();
        chk($sformatf("v%0d latency", idx), n, got.lat);
        if (!res_valid) return;
        held_acc = res_acc;
        for (int k = 0; k < v.hold; k++) begin
            cmd_valid = k[0] ? 1'b0 : 1'b1;
            cmd_load  = 1'b1;
            cmd_b     = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk($sformatf("v%0d hold%0d valid/ready", idx, k), {res_valid, cmd_ready}, 2'b10);
            chk($sformatf("v%0d hold%0d acc", idx, k), res_acc, held_acc);
        end
        cmd_valid = 1'b0;
        chk($sformatf("v%0d res_acc", idx), res_acc, got.acc);
        chk($sformatf("v%0d res_carry", idx), res_carry, got.carry);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk($sformatf("v%0d back to idle", idx), {cmd_ready, res_valid, busy}, 3'b100);
    endtask

    initial begin
        //           load  op     b     rep  hold acc   carry
        vecs[0]  = '{1'b1, 2'b11, 4'h5, 3'd3, 0, 4'h5, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 4'h3, 3'd2, 0, 4'hE, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 4'h1, 3'd0, 0, 4'h0, 1'b1};
        vecs[3]  = '{1'b1, 2'b00, 4'hC, 3'd0, 0, 4'hC, 1'b0};
        vecs[4]  = '{1'b0, 2'b10, 4'hA, 3'd0, 0, 4'h8, 1'b0};
        vecs[5]  = '{1'b0, 2'b11, 4'hF, 3'd1, 0, 4'h8, 1'b0};
        vecs[6]  = '{1'b0, 2'b00, 4'hF, 3'd0, 0, 4'h7, 1'b1};
        vecs[7]  = '{1'b0, 2'b01, 4'h0, 3'd7, 0, 4'hF, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 4'h0, 3'd0, 0, 4'h0, 1'b1};
        vecs[9]  = '{1'b0, 2'b00, 4'h0, 3'd0, 0, 4'h0, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 4'h5, 3'd2, 0, 4'h5, 1'b0};
        vecs[11] = '{1'b0, 2'b00, 4'hF, 3'd0, 3, 4'h4, 1'b1};
        vecs[12] = '{1'b0, 2'b10, 4'hF, 3'd0, 0, 4'h4, 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_load  = 1'b0;
        cmd_b     = 4'h0;
        cmd_rep   = 3'd0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset outputs", {cmd_ready, res_valid, busy, res_carry}, 4'b1000);
        chk("reset acc", res_acc, 4'h0);

        for (int i = 0; i < 13; i++) begin
            run_cmd(i, vecs[i]);
        end

        // Reset while the second of six iterations is due.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 2'b00;
        cmd_b     = 4'h1;
        cmd_rep   = 3'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst seq after iter1", res_acc, 4'h5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst seq outputs", {cmd_ready, res_valid, busy, res_carry}, 4'b1000);
        chk("rst seq acc", res_acc, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rst seq quiet%0d", k), {res_valid, busy}, 2'b00);
        end
        run_cmd(13, '{1'b0, 2'b00, 4'h3, 3'd0, 0, 4'h3, 1'b0});
        chk("scoreboard empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
